dram_ctrl: RTL and testbench

- Initiator side of the SIMM memory array. It takes single-word host read/write requests and generates the multiplexed row/column address, per-bank active-low RAS strobes, CAS and WE for the 8-bank (4 SIMM × 2 RAS) array.
- It also issues periodic CAS-before-RAS (CBR) refresh to all banks.
- It sits between the host bus and the SIMM array top level.

---
 rtl/dram_pkg.sv | 27 ++
 rtl/dram_refresh_timer.sv | 39 +++
 rtl/dram_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dram_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared types, widths and RAS decode for the SIMM array controller
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    PRE,
    REF_CAS,
    REF_RAS
  } state_t;

  localparam int BANK_W    = 3;
  localparam int ROW_W     = 9;
  localparam int COL_W     = 9;
  localparam int DATA_W    = 16;
  localparam int NUM_BANKS = 1 << BANK_W;

  // One-hot-low RAS vector: only the addressed bank's strobe is asserted.
  function automatic logic [NUM_BANKS-1:0] bank_ras_n(input logic [BANK_W-1:0] bank);
    logic [NUM_BANKS-1:0] r;
    r       = '1;
    r[bank] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - free-running refresh interval counter with a single pending flag
module dram_refresh_timer #(
  parameter int REF_INTERVAL = 390
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic ref_pending
);

  localparam int CNT_W = $clog2(REF_INTERVAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             wrap;

  // A wrap coinciding with a clear wins, so no refresh interval is ever lost.
  always_comb begin
    wrap   = (cnt_q == LAST);
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    pend_d = pend_q;
    if (clear) pend_d = 1'b0;
    if (wrap)  pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pending = pend_q;

endmodule

// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - single-word host access and CBR refresh sequencer for the 8-bank SIMM array
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RAS        = 3,
  parameter int T_RP         = 2,
  parameter int REF_INTERVAL = 390
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    req_we,
  input  logic [20:0]             req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    ready,
  output logic                    ack,
  output logic [DATA_W-1:0]       rdata,
  output logic [8:0]              dram_addr,
  output logic [NUM_BANKS-1:0]    ras_n,
  output logic                    cas_n,
  output logic                    we_n,
  output logic [DATA_W-1:0]       dq_out,
  output logic                    dq_oe,
  input  logic [DATA_W-1:0]       dq_in
);

  localparam logic [3:0] T_RCD_W = 4'(T_RCD);
  localparam logic [3:0] T_CAS_W = 4'(T_CAS);
  localparam logic [3:0] T_RAS_W = 4'(T_RAS);
  localparam logic [3:0] T_RP_W  = 4'(T_RP);

  state_t              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d;
  logic                ref_pending;
  logic                ref_clear;
  logic                last;

  dram_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_refresh_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (ref_clear),
    .ref_pending(ref_pending)
  );

  assign ready = (state_q == IDLE) && !ref_pending;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bank_d    = bank_q;
    row_d     = row_q;
    col_d     = col_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    ref_clear = 1'b0;
    last      = (wait_q == 4'd1);
    case (state_q)
      IDLE: begin
        // Refresh is checked first so a pending refresh starves the host.
        if (ref_pending) begin
          state_d   = REF_CAS;
          wait_d    = 4'd1;
          ref_clear = 1'b1;
        end else if (req) begin
          bank_d  = req_addr[20:18];
          row_d   = req_addr[17:9];
          col_d   = req_addr[8:0];
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = ROW;
          wait_d  = T_RCD_W;
        end
      end
      ROW: begin
        if (last) begin
          state_d = COL;
          wait_d  = T_CAS_W;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      COL: begin
        if (last) begin
          state_d = PRE;
          wait_d  = T_RP_W;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = dq_in;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      PRE: begin
        if (last) state_d = IDLE;
        else      wait_d  = wait_q - 4'd1;
      end
      REF_CAS: begin
        state_d = REF_RAS;
        wait_d  = T_RAS_W;
      end
      REF_RAS: begin
        if (last) begin
          state_d = PRE;
          wait_d  = T_RP_W;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the registered state so reset forces them inactive at once.
  always_comb begin
    ras_n     = '1;
    cas_n     = 1'b1;
    we_n      = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    dram_addr = '0;
    case (state_q)
      ROW: begin
        ras_n     = bank_ras_n(bank_q);
        dram_addr = row_q;
      end
      COL: begin
        ras_n     = bank_ras_n(bank_q);
        cas_n     = 1'b0;
        dram_addr = col_q;
        we_n      = ~we_q;
        dq_oe     = we_q;
        dq_out    = wdata_q;
      end
      REF_CAS: cas_n = 1'b0;
      REF_RAS: begin
        cas_n = 1'b0;
        ras_n = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - randomized bench for dram_ctrl against a per-cycle schedule model
module tb_dram_ctrl;

  localparam int T_RCD = 2;
  localparam int T_CAS = 2;
  localparam int T_RAS = 3;
  localparam int T_RP  = 2;
  localparam int RI    = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        req_we;
  logic [20:0] req_addr;
  logic [15:0] req_wdata;
  logic        ready;
  logic        ack;
  logic [15:0] rdata;
  logic [8:0]  dram_addr;
  logic [7:0]  ras_n;
  logic        cas_n;
  logic        we_n;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [15:0] dq_in;

  int checks   = 0;
  int failures = 0;

  dram_ctrl #(
    .T_RCD(T_RCD), .T_CAS(T_CAS), .T_RAS(T_RAS), .T_RP(T_RP), .REF_INTERVAL(RI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready), .ack(ack), .rdata(rdata),
    .dram_addr(dram_addr), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
  );

  always #5 clk = ~clk;

  // Model: each future cycle of a committed operation is one queue entry.
  typedef struct packed {
    logic [7:0]  ras;
    logic        cas;
    logic        we;
    logic        oe;
    logic [15:0] dq;
    logic [8:0]  addr;
    logic        ack;
    logic        cap;
  } exp_t;

  exp_t        q[$];
  logic        pend_m  = 1'b0;
  int          cyc_m   = 0;
  logic [15:0] rdata_m = '0;
  bit          m_idle;

  function automatic exp_t idle_e();
    exp_t e;
    e      = '0;
    e.ras  = 8'hFF;
    e.cas  = 1'b1;
    e.we   = 1'b1;
    return e;
  endfunction

  task automatic push_access(input logic [20:0] a, input logic w, input logic [15:0] d);
    exp_t e;
    logic [7:0] r;
    r = ~(8'd1 << a[20:18]);
    for (int i = 0; i < T_RCD; i++) begin
      e = idle_e(); e.ras = r; e.addr = a[17:9]; q.push_back(e);
    end
    for (int i = 0; i < T_CAS; i++) begin
      e = idle_e(); e.ras = r; e.cas = 1'b0; e.we = ~w; e.oe = w; e.dq = d;
      e.addr = a[8:0]; e.cap = !w && (i == T_CAS - 1); q.push_back(e);
    end
    for (int i = 0; i < T_RP; i++) begin
      e = idle_e(); e.ack = (i == 0); q.push_back(e);
    end
  endtask

  task automatic push_refresh();
    exp_t e;
    e = idle_e(); e.cas = 1'b0; q.push_back(e);
    for (int i = 0; i < T_RAS; i++) begin
      e = idle_e(); e.cas = 1'b0; e.ras = 8'h00; q.push_back(e);
    end
    for (int i = 0; i < T_RP; i++) q.push_back(idle_e());
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      pend_m  = 1'b0;
      cyc_m   = 0;
      rdata_m = '0;
    end else begin
      m_idle = (q.size() == 0);
      if (!m_idle) begin
        if (q[0].cap) rdata_m = dq_in;
        void'(q.pop_front());
      end else if (pend_m) begin
        push_refresh();
        pend_m = 1'b0;
      end else if (req) begin
        push_access(req_addr, req_we, req_wdata);
      end
      cyc_m++;
      if (cyc_m % RI == 0) pend_m = 1'b1;
    end
  end

  always @(negedge clk) begin : cmp
    exp_t e;
    logic exp_ready;
    if (rst_n) begin
      e         = (q.size() == 0) ? idle_e() : q[0];
      exp_ready = (q.size() == 0) && !pend_m;
      checks++;
      if ({ready, ras_n, cas_n, we_n, dq_oe, dq_out, dram_addr, ack, rdata} !==
          {exp_ready, e.ras, e.cas, e.we, e.oe, e.dq, e.addr, e.ack, rdata_m}) begin
        failures++;
        $display("FAIL cycle_cmp cyc=%0d actual ready=%b ras_n=%h cas_n=%b we_n=%b oe=%b dq_out=%h addr=%h ack=%b rdata=%h expected ready=%b ras_n=%h cas_n=%b we_n=%b oe=%b dq_out=%h addr=%h ack=%b rdata=%h",
                 cyc_m, ready, ras_n, cas_n, we_n, dq_oe, dq_out, dram_addr, ack, rdata,
                 exp_ready, e.ras, e.cas, e.we, e.oe, e.dq, e.addr, e.ack, rdata_m);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; dq_in = '0;
    step(3);
    chk("rst_ready", ready, 1);
    chk("rst_ras", ras_n, 8'hFF);
    chk("rst_cas", cas_n, 1);
    chk("rst_oe", dq_oe, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", ack, 0);
    rst_n = 1'b1;

    // Read: bank 2, row 0x109, col 0x034
    req = 1'b1; req_we = 1'b0; req_addr = 21'h0A1234; dq_in = 16'hBEEF;
    step(1); req = 1'b0;
    chk("rd_row_ras", ras_n, 8'hFB);
    chk("rd_row_addr", dram_addr, 9'h109);
    chk("rd_row_cas", cas_n, 1);
    step(2);
    chk("rd_col_cas", cas_n, 0);
    chk("rd_col_addr", dram_addr, 9'h034);
    chk("rd_col_we", we_n, 1);
    step(2);
    chk("rd_ack", ack, 1);
    chk("rd_rdata", rdata, 16'hBEEF);
    step(1);
    chk("rd_ack_pulse", ack, 0);
    step(1);
    chk("rd_ready_back", ready, 1);

    // Write to highest address
    req = 1'b1; req_we = 1'b1; req_addr = 21'h1FFFFF; req_wdata = 16'h5A5A;
    step(1); req = 1'b0;
    chk("wr_row_ras", ras_n, 8'h7F);
    chk("wr_row_addr", dram_addr, 9'h1FF);
    step(2);
    chk("wr_col_we", we_n, 0);
    chk("wr_col_oe", dq_oe, 1);
    chk("wr_col_dq", dq_out, 16'h5A5A);
    step(1);
    chk("wr_col2_oe", dq_oe, 1);
    step(1);
    chk("wr_ack", ack, 1);
    chk("wr_pre_oe", dq_oe, 0);
    step(2);

    // Back-to-back with req held high
    req = 1'b1; req_we = 1'b0; req_addr = 21'($urandom);
    for (int i = 0; i < 20 && !ack; i++) step(1);
    chk("b2b_ack", ack, 1);
    step(1);
    chk("b2b_pre2_ras", ras_n, 8'hFF);
    step(1);
    chk("b2b_idle_ras", ras_n, 8'hFF);
    chk("b2b_idle_ready", ready, 1);
    step(1);
    chk("b2b_second_row", ras_n != 8'hFF, 1);
    req = 1'b0;

    // Idle refresh: pending set on edge 40, REF_CAS after edge 41
    while (cyc_m < RI) step(1);
    chk("ref_ready_low", ready, 0);
    step(1);
    chk("ref_cas_cas", cas_n, 0);
    chk("ref_cas_ras", ras_n, 8'hFF);
    step(1);
    chk("ref_ras_all", ras_n, 8'h00);
    step(3);
    chk("ref_pre_ras", ras_n, 8'hFF);
    chk("ref_pre_noack", ack, 0);
    step(2);
    chk("ref_ready_back", ready, 1);

    // Collision: accept on edge 77 so pending rises in the last COL cycle
    while (cyc_m < 2 * RI - 4) step(1);
    req = 1'b1; req_we = 1'b0; req_addr = 21'($urandom); dq_in = 16'h1357;
    while (cyc_m < 2 * RI + 1) step(1);
    chk("col_ack", ack, 1);
    chk("col_rdata", rdata, 16'h1357);
    step(2);
    chk("col_ready_blocked", ready, 0);
    step(1);
    chk("col_ref_cas", cas_n, 0);
    chk("col_ref_ras", ras_n, 8'hFF);
    step(5);
    chk("col_ready_pre", ready, 0);
    step(1);
    chk("col_ready_back", ready, 1);
    step(1);
    chk("col_accept", ras_n != 8'hFF, 1);
    req = 1'b0;
    step(8);

    // Asynchronous reset in the middle of a write's COL state
    req = 1'b1; req_we = 1'b1; req_addr = 21'($urandom); req_wdata = 16'hC3C3;
    step(1); req = 1'b0;
    step(2);
    chk("arst_pre_oe", dq_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ras", ras_n, 8'hFF);
    chk("arst_cas", cas_n, 1);
    chk("arst_oe", dq_oe, 0);
    chk("arst_we", we_n, 1);
    step(1);
    rst_n = 1'b1;
    chk("arst_ready", ready, 1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("arst_noack", ack, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req       = ($urandom_range(0, 2) != 0);
      req_we    = 1'($urandom);
      req_addr  = 21'($urandom);
      req_wdata = 16'($urandom);
      dq_in     = 16'($urandom);
      step(1);
    end
    req = 1'b0;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
